// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - mode encodings and width-generic gray/binary helpers
package gray_pkg;

  localparam logic [1:0] MODE_B2G  = 2'b00;
  localparam logic [1:0] MODE_G2B  = 2'b01;
  localparam logic [1:0] MODE_GINC = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  // Callers zero-extend their word to this width and truncate the result;
  // zero upper bits leave the low bits of both transforms unchanged.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_skid_buf.sv
// rtl/gray_skid_buf.sv - two-entry in-order buffer with registered ready
module gray_skid_buf #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_tvalid_i,
  output logic         s_tready_o,
  input  logic [W-1:0] s_tdata_i,
  output logic         m_tvalid_o,
  input  logic         m_tready_i,
  output logic [W-1:0] m_tdata_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic [1:0]   occ_q, occ_d;
  logic         live_q;
  logic         push_w, pop_w;

  // live_q keeps ready low until the first edge after reset release.
  assign s_tready_o = live_q && (occ_q != 2'd2);
  assign m_tvalid_o = (occ_q != 2'd0);
  assign m_tdata_o  = mem_q[rd_q];

  assign push_w = s_tvalid_i && s_tready_o;
  assign pop_w  = m_tvalid_o && m_tready_i;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push_w) begin
      mem_d[wr_q] = s_tdata_i;
      wr_d        = ~wr_q;
    end
    if (pop_w) begin
      rd_d = ~rd_q;
    end
    case ({push_w, pop_w})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
      live_q   <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      occ_q  <= occ_d;
      live_q <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_stream_conv.sv
// rtl/gray_stream_conv.sv - per-beat gray code converter stream stage with beat counter
module gray_stream_conv
  import gray_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_mode,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] beat_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     b2g_w, g2b_w, ginc_bin_w, ginc_w, conv_w;
  logic [N+1:0]     buf_out_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign b2g_w      = N'(bin2gray(GRAY_MAX_W'(in_data)));
  assign g2b_w      = N'(gray2bin(GRAY_MAX_W'(in_data)));
  assign ginc_bin_w = g2b_w + N'(1);
  assign ginc_w     = N'(bin2gray(GRAY_MAX_W'(ginc_bin_w)));

  always_comb begin
    conv_w = in_data;
    case (in_mode)
      MODE_B2G:  conv_w = b2g_w;
      MODE_G2B:  conv_w = g2b_w;
      MODE_GINC: conv_w = ginc_w;
      MODE_PASS: conv_w = in_data;
      default:   conv_w = in_data;
    endcase
  end

  // Mode travels with its result so out_mode always names the oldest entry.
  gray_skid_buf #(
    .W (N + 2)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid_i (in_valid),
    .s_tready_o (in_ready),
    .s_tdata_i  ({in_mode, conv_w}),
    .m_tvalid_o (out_valid),
    .m_tready_i (out_ready),
    .m_tdata_o  (buf_out_w)
  );

  assign out_mode   = buf_out_w[N+1:N];
  assign out_data   = buf_out_w[N-1:0];
  assign beat_count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_stream_conv.sv
// tb/tb_gray_stream_conv.sv - self-checking bench for gray_stream_conv
module tb_gray_stream_conv;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [N-1:0] in_data = '0;
  logic [1:0]   in_mode = 2'b00;

  logic         in_ready, out_valid;
  logic [N-1:0] out_data;
  logic [1:0]   out_mode;
  logic [15:0]  beat_count;

  logic         in_ready4, out_valid4;
  logic [N-1:0] out_data4;
  logic [1:0]   out_mode4;
  logic [3:0]   beat_count4;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   exp_cnt  = 0;
  int   exp_cnt4 = 0;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] din;
    logic [3:0] dout;
  } vec_t;
  vec_t tbl [10];

  gray_stream_conv #(.N(N), .CNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_mode   (out_mode),
    .cnt_clr    (cnt_clr),
    .beat_count (beat_count)
  );

  gray_stream_conv #(.N(N), .CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready4),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .out_data   (out_data4),
    .out_mode   (out_mode4),
    .cnt_clr    (cnt_clr),
    .beat_count (beat_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray decode by search: the binary value whose gray image matches.
  function automatic int ref_g2b(input int g);
    for (int v = 0; v < 16; v++) begin
      if (((v ^ (v >> 1)) & 15) == g) return v;
    end
    return 0;
  endfunction

  function automatic logic [3:0] ref_conv(input logic [1:0] m, input logic [3:0] d);
    int di, r;
    di = int'(d);
    case (m)
      2'b00:   r = di ^ (di >> 1);
      2'b01:   r = ref_g2b(di);
      2'b10:   begin r = (ref_g2b(di) + 1) % 16; r = r ^ (r >> 1); end
      default: r = di;
    endcase
    return 4'(r);
  endfunction

  // One clock: score handshakes seen before the edge, then check state after it.
  task automatic cycle();
    bit push, pop;
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;
    if (pop) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got data %0h with empty model", out_data);
      end else begin
        chk("pop_data", out_data, exp_q[0].data);
        chk("pop_mode", out_mode, exp_q[0].mode);
        exp_q.pop_front();
      end
    end
    if (push) exp_q.push_back('{in_mode, ref_conv(in_mode, in_data)});
    if (cnt_clr) begin
      exp_cnt  = 0;
      exp_cnt4 = 0;
    end else if (pop) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("out_valid4", out_valid4, exp_q.size() != 0);
    chk("in_ready4", in_ready4, exp_q.size() < 2);
    if (exp_q.size() != 0) begin
      chk("front_data", out_data, exp_q[0].data);
      chk("front_mode", out_mode, exp_q[0].mode);
      chk("front_data4", out_data4, exp_q[0].data);
      chk("front_mode4", out_mode4, exp_q[0].mode);
    end
    chk("beat_count", beat_count, exp_cnt);
    chk("beat_count4", beat_count4, exp_cnt4);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle();
    chk("drain_empty", out_valid, 1'b0);
  endtask

  task automatic stream(input int n);
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_mode  = 2'($urandom_range(0, 3));
      in_data  = 4'($urandom_range(0, 15));
      cycle();
      chk("stream_ready", in_ready, 1'b1);
    end
    drain();
  endtask

  initial begin
    tbl[0] = '{2'b00, 4'b1011, 4'b1110};
    tbl[1] = '{2'b01, 4'b1110, 4'b1011};
    tbl[2] = '{2'b10, 4'b0011, 4'b0010};
    tbl[3] = '{2'b10, 4'b1000, 4'b0000};
    tbl[4] = '{2'b11, 4'b0101, 4'b0101};
    tbl[5] = '{2'b00, 4'b1111, 4'b1000};
    tbl[6] = '{2'b01, 4'b1000, 4'b1111};
    tbl[7] = '{2'b10, 4'b0000, 4'b0001};
    tbl[8] = '{2'b01, 4'b0001, 4'b0001};
    tbl[9] = '{2'b00, 4'b0000, 4'b0000};

    // Reset state, asserted between clock edges.
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_mode", out_mode, 2'b00);
    chk("rst_beat_count", beat_count, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    chk("first_edge_ready", in_ready, 1'b1);

    // Table vectors, back-to-back with the output always ready: 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_mode  = tbl[i].mode;
      in_data  = tbl[i].din;
      cycle();
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_data", out_data, tbl[i].dout);
      chk("vec_mode", out_mode, tbl[i].mode);
    end
    drain();

    // Streaming 20 beats from a cleared counter.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    stream(20);
    chk("stream20_count", beat_count, 16'd20);
    chk("stream20_count4", beat_count4, 4'd15);

    // 17 transfers saturate the narrow counter.
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    stream(17);
    chk("sat17_count", beat_count, 16'd17);
    chk("sat17_count4", beat_count4, 4'd15);

    // Clear wins over a coincident output transfer.
    in_valid = 1'b1;
    in_mode  = 2'b11;
    in_data  = 4'h7;
    cycle();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    cycle();
    cnt_clr  = 1'b0;
    chk("clr_xfer_count", beat_count, 16'd0);
    chk("clr_xfer_count4", beat_count4, 4'd0);

    // Backpressure: A and B accepted, C waits, A held for 4 stalled cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b11;
    in_data   = 4'h3;
    cycle();
    chk("bp_hold_a0", out_data, 4'h3);
    in_data = 4'h5;
    cycle();
    chk("bp_full", in_ready, 1'b0);
    chk("bp_hold_a1", out_data, 4'h3);
    in_data = 4'h9;
    cycle();
    chk("bp_hold_a2", out_data, 4'h3);
    cycle();
    chk("bp_hold_a3", out_data, 4'h3);
    chk("bp_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    cycle();
    chk("bp_second_b", out_data, 4'h5);
    cycle();
    chk("bp_third_c", out_data, 4'h9);
    in_valid = 1'b0;
    cycle();
    chk("bp_empty", out_valid, 1'b0);

    // Randomized handshakes against the queue model.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_mode   = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      cnt_clr   = ($urandom_range(0, 31) == 0);
      cycle();
    end
    cnt_clr = 1'b0;
    drain();

    // Reset mid-operation with two beats buffered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b11;
    in_data   = 4'hA;
    cycle();
    in_data = 4'h6;
    cycle();
    chk("pre_rst_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_out_data", out_data, 4'h0);
    chk("mid_rst_out_mode", out_mode, 2'b00);
    chk("mid_rst_count", beat_count, 16'h0);
    exp_q.delete();
    exp_cnt  = 0;
    exp_cnt4 = 0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 4'hD;
    out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    cycle();
    chk("rst_first_valid", out_valid, 1'b1);
    chk("rst_first_data", out_data, 4'hB);
    in_valid = 1'b0;
    cycle();
    chk("rst_no_stale", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_stream_conv.md
GRAY_STREAM_CONV -- requirements
Module: gray_stream_conv

Interface
REQ-001 SHALL have parameter N, default 4: data width in bits, legal range N >= 2.
REQ-002 SHALL have parameter CNT_W, default 16: width of the beat counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an input beat.
REQ-007 SHALL have port in_data, input, N bits: the input word.
REQ-008 SHALL have port in_mode, input, 2 bits: the per-beat operation (00 bin->gray, 01 gray->bin, 10 gray increment, 11 pass-through).
REQ-009 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage accepts the output beat.
REQ-011 SHALL have port out_data, output, N bits: the result word.
REQ-012 SHALL have port out_mode, output, 2 bits: the mode that produced out_data.
REQ-013 SHALL have port cnt_clr, input, 1 bit: synchronous clear of the beat counter.
REQ-014 SHALL have port beat_count, output, CNT_W bits: the number of completed output handshakes.

Function
REQ-015 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-016 Mode 00 SHALL produce in_data XOR (in_data >> 1).
REQ-017 Mode 01 SHALL produce out[N-1] = in[N-1] and, for i from N-2 down to 0, out[i] = out[i+1] XOR in[i].
REQ-018 Mode 10 SHALL convert gray to binary, add 1 modulo 2^N, and convert back to gray; binary all-ones wraps to gray 0.
REQ-019 Mode 11 SHALL produce out_data = in_data unchanged.
REQ-020 Results SHALL be computed at input acceptance and stored in a 2-entry in-order buffer together with their mode.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge t with the buffer empty SHALL give out_valid=1 after edge t.
REQ-022 in_ready SHALL be 1 exactly when buffer occupancy < 2, driven from registered state only, with no combinational path from out_ready.
REQ-023 A simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1 with order preserved.
REQ-024 At occupancy 2, a pop SHALL free one slot and no push SHALL occur in that same cycle.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_mode SHALL hold stable.
REQ-026 out_valid SHALL be 1 exactly when occupancy > 0; out_data and out_mode SHALL always present the oldest entry.
REQ-027 beat_count SHALL increment on each output transfer and saturate at 2^CNT_W-1.
REQ-028 When cnt_clr coincides with an output transfer, cnt_clr SHALL take priority and beat_count SHALL become 0.
REQ-029 No beat SHALL be dropped, duplicated or reordered under any in_valid/out_ready pattern.

Reset
REQ-030 While rst=1, the block SHALL force occupancy 0, out_valid=0, in_ready=0, out_data=0, out_mode=00 and beat_count=0, independent of clk.
REQ-031 After rst is deasserted, in_ready SHALL be 1 from the first rising edge onward.
REQ-032 Reset asserted mid-operation SHALL discard all buffered beats, and no stale beat SHALL appear after release.

Structure
REQ-033 Package gray_pkg SHALL hold the mode encoding constants (MODE_B2G, MODE_G2B, MODE_GINC, MODE_PASS) and width-generic bin2gray and gray2bin functions.
REQ-034 The 2-entry buffer SHALL be the single sub-module gray_skid_buf, parameterised by payload width N+2.
REQ-035 The conversion logic SHALL be combinational, located in the top level, and use only the gray_pkg functions.

Verification
REQ-036 With N=4 and out_ready=1: mode 00 with 1011 -> 1110; mode 01 with 1110 -> 1011; each SHALL arrive 1 cycle after acceptance.
REQ-037 With N=4, mode 10: 0011 -> 0010 (binary 2 to 3); 1000 -> 0000 (binary 15 wraps to 0).
REQ-038 Backpressure: out_ready=0 for 4 cycles while in_valid=1 with beats A,B,C; A and B SHALL be accepted, in_ready SHALL drop after B, and out_data SHALL hold A; after release the output order SHALL be A,B,C.
REQ-039 Streaming: 20 back-to-back beats with both sides always ready SHALL give in_ready=1 throughout, 20 outputs in order, and beat_count=20.
REQ-040 Counter: with CNT_W=4, 17 output transfers SHALL give beat_count=15; cnt_clr together with a transfer SHALL give 0.
REQ-041 Reset with 2 beats buffered SHALL give out_valid=0 immediately (asynchronously), and the next output after release SHALL be the first new beat.
